// File: rtl/data_mem_responder.sv
// Memory-bus responder with programmable wait states and a byte-enabled word RAM.
// Define MEM_BUS_ERR_EN to flag addresses >= DEPTH as errors instead of aliasing them.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BYTES = DATA_W / 8;
  localparam logic [3:0] LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                w_start;
  logic                w_addr_bad;
  logic [IDX_W-1:0]    w_idx;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BYTES-1:0]    r_be;

  logic                r_ack;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  assign w_start = (r_state == S_IDLE) && req;
  assign w_idx   = IDX_W'(32'(r_addr) % 32'(DEPTH));

`ifdef MEM_BUS_ERR_EN
  logic [31:0] w_addr_ext;
  assign w_addr_ext = 32'(r_addr);
  assign w_addr_bad = (w_addr_ext >= 32'(DEPTH));
`else
  assign w_addr_bad = 1'b0;
`endif

  // Control stage: state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Capture stage: request fields frozen at the sampling edge
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_be    <= be;
    end
  end

  // Response stage: ack/err/rdata raised on the edge leaving RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack  <= (r_state == S_RESP);
      r_busy <= (r_state != S_IDLE);
      r_err  <= (r_state == S_RESP) && w_addr_bad;
      if ((r_state == S_RESP) && !r_we)
        r_rdata <= w_addr_bad ? '0 : r_mem[w_idx];
    end
  end

  // State is forced to IDLE asynchronously, so an aborted write never reaches this
  always_ff @(posedge clk) begin
    if ((r_state == S_RESP) && r_we && !w_addr_bad) begin
      for (int b = 0; b < BYTES; b++) begin
        if (r_be[b])
          r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign ack   = r_ack;
  assign busy  = r_busy;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver predicts responses, monitor checks them.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int WS    = 2;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          err;

  data_mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .ack(ack), .rdata(rdata), .busy(busy), .err(err)
  );

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          er;
    int          ecyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [DEPTH];
  logic [31:0] hold;
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_bad(logic [AW-1:0] a);
`ifdef MEM_BUS_ERR_EN
    return (int'(a) >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one request and predicts its response from the memory model
  task automatic issue(bit w, logic [AW-1:0] a, logic [31:0] d, logic [3:0] b);
    exp_t       e;
    logic [7:0] idx;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    idx    = a[7:0];
    e.rd   = !w;
    e.er   = is_bad(a);
    e.ecyc = cyc;
    e.data = 32'h0;
    if (!e.er) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        e.data = model[idx];
      end
    end
    q.push_back(e);
    repeat (WS + 1) begin
      @(negedge clk);
      req = 1'($urandom); we = 1'($urandom); addr = AW'($urandom);
      wdata = $urandom; be = 4'($urandom);
      @(posedge clk);
    end
  endtask

  task automatic idle(int n);
    @(negedge clk);
    req = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   eb;
    if (rst_n) begin
      eb = (q.size() > 0) && (cyc >= q[0].ecyc + 2) && (cyc <= q[0].ecyc + 2 + WS);
      check("busy", 32'(busy), 32'(eb));
      if (ack) begin
        if (q.size() == 0) begin
          check("spurious_ack", 32'(ack), 32'h0);
        end else begin
          e = q.pop_front();
          check("ack_latency", cyc, e.ecyc + 2 + WS);
          check("err", 32'(err), 32'(e.er));
          if (e.rd) hold = e.data;
        end
      end else begin
        check("err_idle", 32'(err), 32'h0);
      end
      check("rdata", rdata, hold);
    end
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    hold  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i), $urandom, 4'hF);
    idle(2);

    issue(1'b1, 9'h010, 32'hDEADBEEF, 4'hF);
    idle(1);
    issue(1'b0, 9'h010, 32'h0, 4'h0);
    idle(5);
    issue(1'b1, 9'h010, 32'h11223344, 4'b0101);
    issue(1'b0, 9'h010, 32'h0, 4'h0);
    idle(3);
    issue(1'b0, 9'h010, 32'h0, 4'h0);
    issue(1'b0, 9'h011, 32'h0, 4'h0);
    issue(1'b0, 9'h012, 32'h0, 4'h0);
    idle(3);

    // Reset in the middle of a write; the write must not land
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 9'h010; wdata = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ack", 32'(ack), 32'h0);
    check("abort_rdata", rdata, 32'h0);
    hold = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);
    issue(1'b0, 9'h010, 32'h0, 4'h0);
    idle(2);

    issue(1'b1, 9'h1FF, 32'hA5A5A5A5, 4'hF);
    issue(1'b0, 9'h0FF, 32'h0, 4'h0);
    issue(1'b0, 9'h1FF, 32'h0, 4'h0);
    issue(1'b1, 9'h000, 32'h01020304, 4'h0);
    issue(1'b0, 9'h000, 32'h0, 4'h0);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), AW'($urandom), $urandom, 4'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end

    idle(10);
    check("drain", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
